// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// N-channel conditioner for front-panel buttons and switches. Each channel
// runs its raw pin through a synchronizer, a debounce filter, registered
// rise/fall pulse generation, and an auto-repeat FSM that emits a "press"
// pulse on the initial press and then periodically while the button is held.
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset (clears every flop)
//   noisy_in      raw asynchronous pin inputs, one bit per channel
//   repeat_en_in  per-channel auto-repeat enable (synchronous to clk_in)
//   clean_out     debounced level
//   rise_out      one-cycle pulse when clean_out goes 0->1
//   fall_out      one-cycle pulse when clean_out goes 1->0
//   press_out     one-cycle pulse on initial press and on each auto-repeat
// ---------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_CH            = 5,
   parameter int NSYNC           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic [N_CH-1:0] noisy_in,
   input  logic [N_CH-1:0] repeat_en_in,
   output logic [N_CH-1:0] clean_out,
   output logic [N_CH-1:0] rise_out,
   output logic [N_CH-1:0] fall_out,
   output logic [N_CH-1:0] press_out
);

   // Debounce counter only ever reaches DEBOUNCE_CYCLES-1.
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   // Repeat timer only ever reaches max(REPEAT_DELAY, REPEAT_PERIOD)-1.
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [NSYNC-1:0] sync_reg;
         logic             synced;
         logic [CW-1:0]    cnt_reg, cnt_next;
         logic             clean_reg, clean_next;
         logic             rise_reg, rise_next;
         logic             fall_reg, fall_next;
         rep_state_t       state_reg, state_next;
         logic [TW-1:0]    timer_reg, timer_next;
         logic             press_reg, press_next;

         // ---------------- synchronizer ----------------
         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[NSYNC-2:0], noisy_in[gi]};
            end
         end

         assign synced = sync_reg[NSYNC-1];

         // ---------------- debounce filter ----------------
         // Any synced cycle that agrees with the clean level restarts the
         // count, so only an uninterrupted run of DEBOUNCE_CYCLES differing
         // samples flips the clean level.
         always_comb begin
            cnt_next   = cnt_reg;
            clean_next = clean_reg;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            if (synced == clean_reg) begin
               cnt_next = '0;
            end else if (cnt_reg == DB_LAST) begin
               cnt_next   = '0;
               clean_next = ~clean_reg;
               rise_next  = ~clean_reg;
               fall_next  = clean_reg;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               cnt_reg   <= '0;
               clean_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               cnt_reg   <= cnt_next;
               clean_reg <= clean_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
            end
         end

         // ---------------- auto-repeat FSM ----------------
         // rise_next/fall_next are the edge events that are being registered
         // this cycle, so press_out lines up with rise_out, and a release
         // takes priority over a repeat that would expire on the same edge.
         always_comb begin
            state_next = state_reg;
            timer_next = timer_reg;
            press_next = 1'b0;
            if (fall_next) begin
               state_next = IDLE;
               timer_next = '0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     if (rise_next) begin
                        press_next = 1'b1;
                        state_next = DELAY;
                        timer_next = '0;
                     end
                  end
                  DELAY: begin
                     if (!repeat_en_in[gi]) begin
                        timer_next = '0;
                     end else if (timer_reg == DELAY_LAST) begin
                        press_next = 1'b1;
                        state_next = REPEAT;
                        timer_next = '0;
                     end else begin
                        timer_next = timer_reg + TW'(1);
                     end
                  end
                  REPEAT: begin
                     if (!repeat_en_in[gi]) begin
                        state_next = DELAY;
                        timer_next = '0;
                     end else if (timer_reg == PERIOD_LAST) begin
                        press_next = 1'b1;
                        timer_next = '0;
                     end else begin
                        timer_next = timer_reg + TW'(1);
                     end
                  end
                  default: begin
                     state_next = IDLE;
                     timer_next = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               state_reg <= IDLE;
               timer_reg <= '0;
               press_reg <= 1'b0;
            end else begin
               state_reg <= state_next;
               timer_reg <= timer_next;
               press_reg <= press_next;
            end
         end

         assign clean_out[gi] = clean_reg;
         assign rise_out[gi]  = rise_reg;
         assign fall_out[gi]  = fall_reg;
         assign press_out[gi] = press_reg;
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with N_CH=2, NSYNC=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs are driven and
// outputs sampled 1 ns after each rising edge. With these parameters a level
// first sampled at edge k appears on clean_out after edge k+5.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [1:0] noisy_in;
   logic [1:0] repeat_en_in;
   logic [1:0] clean_out;
   logic [1:0] rise_out;
   logic [1:0] fall_out;
   logic [1:0] press_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int e1       = 0;   // absolute cycle of ch1's first repeat pulse
   int cnt      = 0;

   button_conditioner #(
      .N_CH(2),
      .NSYNC(2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .noisy_in(noisy_in),
      .repeat_en_in(repeat_en_in),
      .clean_out(clean_out),
      .rise_out(rise_out),
      .fall_out(fall_out),
      .press_out(press_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", tag, obs, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   initial begin
      rst_n_in     = 1'b0;
      noisy_in     = 2'b11;
      repeat_en_in = 2'b00;

      // ---- 1: reset with pins already high ----
      for (int t = 0; t < 3; t++) begin
         tick();
         check_val($sformatf("rst_low_outs_%0d", t), {clean_out, rise_out, fall_out, press_out}, 8'h00);
      end
      rst_n_in = 1'b1;   // released between edges; next edge is edge 0
      for (int t = 0; t < 5; t++) tick();
      check_val("rst_edge4_clean", clean_out, 2'b00);
      tick();            // edge 5
      check_val("rst_edge5_clean", clean_out, 2'b11);
      check_val("rst_edge5_rise",  rise_out,  2'b11);
      check_val("rst_edge5_press", press_out, 2'b11);
      check_val("rst_edge5_fall",  fall_out,  2'b00);
      tick();
      check_val("rst_edge6_pulses", {rise_out, press_out}, 4'b0000);
      check_val("rst_edge6_clean",  clean_out, 2'b11);
      noisy_in = 2'b00;
      for (int t = 0; t < 5; t++) tick();
      check_val("rel_hold_clean", clean_out, 2'b11);
      tick();
      check_val("rel_clean", clean_out, 2'b00);
      check_val("rel_fall",  fall_out,  2'b11);
      check_val("rel_press_rise", {press_out, rise_out}, 4'b0000);
      tick();
      check_val("rel_fall_end", fall_out, 2'b00);

      // ---- 2: glitch rejection, then a minimal valid pulse ----
      noisy_in = 2'b01;
      for (int t = 1; t <= 12; t++) begin
         if (t == 4) noisy_in = 2'b00;
         tick();
         check_val($sformatf("glitch3_t%0d", t), {clean_out[0], rise_out[0], press_out[0]}, 3'b000);
      end
      noisy_in = 2'b01;
      for (int t = 1; t <= 14; t++) begin
         if (t == 5) noisy_in = 2'b00;
         tick();
         check_val($sformatf("pulse4_t%0d", t), {clean_out[0], rise_out[0], fall_out[0]},
                   {(t >= 6 && t <= 9), (t == 6), (t == 10)});
      end

      // ---- 3: auto-repeat on ch0, release clear of a repeat ----
      repeat_en_in = 2'b01;
      noisy_in     = 2'b01;
      for (int t = 1; t <= 50; t++) begin
         if (t == 37) noisy_in = 2'b00;
         tick();
         check_val($sformatf("rep0_t%0d", t), {press_out[0], fall_out[0]},
                   {(t == 6) || (t >= 16 && t <= 40 && ((t - 16) % 3) == 0), (t == 42)});
      end

      // ---- 4: ch1 held with repeat disabled, then enabled mid-hold ----
      noisy_in = 2'b10;
      cnt = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (press_out[1]) cnt++;
         if (t == 6) check_val("norep1_rise", {rise_out[1], press_out[1]}, 2'b11);
      end
      check_val("norep1_press_count", cnt, 1);
      repeat_en_in = 2'b11;   // changed right after edge E
      e1 = cyc + 10;
      for (int t = 1; t <= 15; t++) begin
         tick();
         check_val($sformatf("en1_t%0d", t), press_out[1], (t == 10) || (t == 13));
      end

      // ---- 5: ch0 release on its repeat expiry, ch1 keeps repeating ----
      noisy_in = 2'b11;
      for (int t = 1; t <= 30; t++) begin
         if (t == 20) noisy_in = 2'b10;
         tick();
         check_val($sformatf("race0_t%0d", t), {press_out[0], fall_out[0]},
                   {(t == 6) || (t == 16) || (t == 19) || (t == 22), (t == 25)});
         check_val($sformatf("indep1_t%0d", t), {clean_out[1], press_out[1], fall_out[1]},
                   {1'b1, ((cyc - e1) % 3) == 0, 1'b0});
      end

      // ---- 6: asynchronous reset pulse mid-REPEAT ----
      check_val("arst_pre_clean", clean_out, 2'b10);
      @(posedge clk_in);
      cyc++;
      #3 rst_n_in = 1'b0;
      #1 check_val("arst_outs_zero", {clean_out, rise_out, fall_out, press_out}, 8'h00);
      #2 rst_n_in = 1'b1;
      for (int t = 0; t < 5; t++) tick();
      check_val("arst_edge4_clean", clean_out, 2'b00);
      tick();
      check_val("arst_edge5_clean", clean_out, 2'b10);
      check_val("arst_edge5_rise_press", {rise_out, press_out}, 4'b1010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Parametrised N-channel input conditioner for the front-panel buttons and switches. It replaces the per-signal synchronize/debounce instances and the hand-written edge detectors in the top level. Each channel gets a synchronizer, debounce filter, registered rise/fall pulses, and an optional auto-repeat "press" pulse stream for menu navigation when a button is held. It sits between the board pins and game_controller.

Parameters:
N_CH, 5, number of independent channels (≥1)
NSYNC, 3, synchronizer flop depth (≥2)
DEBOUNCE_CYCLES, 1_000_000, consecutive differing cycles required to change clean state (≥2)
REPEAT_DELAY, 50_000_000, cycles from initial press to first repeat pulse (≥1)
REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (≥1)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  asynchronous active-low reset
noisy_in  input  N_CH  raw asynchronous pin inputs
repeat_en_in  input  N_CH  per-channel auto-repeat enable (synchronous to clk_in)
clean_out  output  N_CH  debounced level
rise_out  output  N_CH  one-cycle pulse on clean 0->1
fall_out  output  N_CH  one-cycle pulse on clean 1->0
press_out  output  N_CH  one-cycle pulse on initial press and on each auto-repeat

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-low on rst_n_in. Every flop (sync chain, counters, FSM, all outputs) clears to 0 on assertion. Channels are fully independent; same logic per channel.
- Sync: NSYNC-flop shift chain. The synced value is the last flop.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - Cleared in any cycle where synced == clean_out.
  - Otherwise increments.
  - When the counter == DEBOUNCE_CYCLES-1 and synced != clean_out, clean_out toggles and the counter clears.
- Debounce latency: a clean edge held on noisy_in from edge k onward sets clean_out at edge k+NSYNC+DEBOUNCE_CYCLES-1. A single synced cycle equal to clean_out restarts the count.
- rise_out/fall_out are registered alongside clean_out. They are high exactly in the first cycle clean_out holds its new value, and never both high.
- Auto-repeat FSM per channel, states IDLE, DELAY, REPEAT. The timer width covers max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: on the clean rise, press_out pulses (coincident with rise_out), the FSM goes to DELAY, and the timer is set to 0.
  - DELAY: the timer increments each cycle while repeat_en_in=1. It is held at 0 while repeat_en_in=0 (no repeats).
    - When the timer == REPEAT_DELAY-1 with repeat_en_in=1: press_out pulses next edge, FSM goes to REPEAT, timer is set to 0.
    - First repeat lands exactly REPEAT_DELAY cycles after the initial press pulse.
  - REPEAT: the timer increments. When it == REPEAT_PERIOD-1: press_out pulses, timer is set to 0.
    - Repeats are spaced exactly REPEAT_PERIOD cycles.
    - repeat_en_in dropping here returns the FSM to DELAY with the timer set to 0.
  - Any state: a clean fall returns the FSM to IDLE in the same edge as fall_out. No press pulse is generated on release, and a pending repeat coinciding with release is suppressed.
- The power-up state is clean=0. If a pin is already high at reset release, it produces a normal rise and press after the debounce latency.
- Reset asserted mid-hold: all outputs drop asynchronously. After release the channel re-qualifies from scratch.
- Counters never wrap; both counters saturate-by-clear as described.

Test Plan:
(Bench parameters: NSYNC=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_CH=2.)
- Reset: rst_n_in low with noisy_in=2'b11 -> all outputs 0 while low. After release, clean_out=2'b11 at edge 5, with rise_out=press_out=2'b11 for one cycle.
- Glitch rejection: noisy_in[0] high for 3 cycles then low -> clean_out[0] stays 0 and no pulses. Then a 4-cycle high -> clean_out[0] rises, rise_out[0] pulses once.
- Auto-repeat: repeat_en_in[0]=1, hold button 30 cycles after clean rise at edge T -> press_out[0] at T, T+10, T+13, T+16, …, until release. On release fall_out[0] pulses and press_out stays 0.
- Repeat disabled: repeat_en_in[1]=0, long hold -> exactly one press_out[1] pulse. Raising repeat_en_in mid-hold at edge E gives the first repeat at E+10.
- Channel independence plus release race: ch0 release debounced on the same edge its repeat timer expires -> fall_out[0]=1, press_out[0]=0. ch1 activity over the same interval is unaffected.
- Async reset mid-REPEAT: rst_n_in pulsed low between clock edges -> outputs 0 immediately. With the button still held, rise and press re-occur 5 edges after release.
